// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one function unit per cycle round-robin and
// registers its result, tag and write enable for broadcast on the following cycle.
module cdb_arbiter #(
   parameter int NUM_FU         = 4,
   parameter int PHYS_REG_WIDTH = 6,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                                      clock,
   input  logic                                      reset_n,
   input  logic                                      clear,
   input  logic [NUM_FU-1:0]                         fu_next_valid,
   input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]         fu_result,
   input  logic [NUM_FU-1:0][PHYS_REG_WIDTH-1:0]     fu_dest_tag,
   input  logic [NUM_FU-1:0]                         fu_dest_tag_wr_en,
   output logic [NUM_FU-1:0]                         fu_broadcasted,
   output logic                                      cdb_valid,
   output logic [DATA_WIDTH-1:0]                     cdb_data,
   output logic [PHYS_REG_WIDTH-1:0]                 cdb_tag,
   output logic                                      cdb_wr_en
);

   localparam int PTR_WIDTH = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam logic [PTR_WIDTH-1:0] LAST_FU = PTR_WIDTH'(NUM_FU - 1);
   localparam logic [PTR_WIDTH:0]   FU_COUNT = (PTR_WIDTH + 1)'(NUM_FU);

   logic [NUM_FU-1:0]   req_ff;
   logic [PTR_WIDTH-1:0] ptr_ff;
   logic [2*NUM_FU-1:0] req_rotated;
   logic [PTR_WIDTH:0]  wrap_sum;
   logic [PTR_WIDTH-1:0] grant_idx;
   logic [PTR_WIDTH-1:0] next_ptr;
   logic                grant_found;
   logic                grant_valid;

   // Rotating the doubled request vector puts ptr_ff at bit 0, so the first set
   // bit is the winner's distance from the pointer.
   always_comb begin
      req_rotated = {req_ff, req_ff} >> ptr_ff;
      grant_found = 1'b0;
      wrap_sum    = '0;
      grant_idx   = '0;
      for (int off = 0; off < NUM_FU; off++) begin
         if (!grant_found && req_rotated[off]) begin
            grant_found = 1'b1;
            wrap_sum    = {1'b0, ptr_ff} + (PTR_WIDTH + 1)'(off);
            if (wrap_sum >= FU_COUNT) begin
               wrap_sum = wrap_sum - FU_COUNT;
            end
            grant_idx = wrap_sum[PTR_WIDTH-1:0];
         end
      end
   end

   assign grant_valid = grant_found & ~clear;
   assign next_ptr    = (grant_idx == LAST_FU) ? '0 : grant_idx + PTR_WIDTH'(1);

   always_comb begin
      fu_broadcasted = '0;
      if (grant_valid) begin
         fu_broadcasted[grant_idx] = 1'b1;
      end
   end

   // Broadcast registers keep their last contents whenever nothing is granted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_ff    <= '0;
         ptr_ff    <= '0;
         cdb_valid <= 1'b0;
         cdb_data  <= '0;
         cdb_tag   <= '0;
         cdb_wr_en <= 1'b0;
      end else begin
         req_ff    <= fu_next_valid & {NUM_FU{~clear}};
         cdb_valid <= grant_valid;
         if (grant_valid) begin
            ptr_ff    <= next_ptr;
            cdb_data  <= fu_result[grant_idx];
            cdb_tag   <= fu_dest_tag[grant_idx];
            cdb_wr_en <= fu_dest_tag_wr_en[grant_idx];
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus random traffic checked
// against a distance-from-pointer round-robin model.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int TW = 6;

   logic                   clock;
   logic                   reset_n;
   logic                   clear;
   logic [N-1:0]           fu_next_valid;
   logic [N-1:0][31:0]     fu_result;
   logic [N-1:0][TW-1:0]   fu_dest_tag;
   logic [N-1:0]           fu_dest_tag_wr_en;
   logic [N-1:0]           fu_broadcasted;
   logic                   cdb_valid;
   logic [31:0]            cdb_data;
   logic [TW-1:0]          cdb_tag;
   logic                   cdb_wr_en;

   logic [N-1:0] m_req;
   int           m_ptr;
   logic         m_valid;
   logic [31:0]  m_data;
   logic [TW-1:0] m_tag;
   logic         m_wr;

   int vectors;
   int miscompares;

   cdb_arbiter #(.NUM_FU(N), .PHYS_REG_WIDTH(TW), .DATA_WIDTH(32)) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .clear             (clear),
      .fu_next_valid     (fu_next_valid),
      .fu_result         (fu_result),
      .fu_dest_tag       (fu_dest_tag),
      .fu_dest_tag_wr_en (fu_dest_tag_wr_en),
      .fu_broadcasted    (fu_broadcasted),
      .cdb_valid         (cdb_valid),
      .cdb_data          (cdb_data),
      .cdb_tag           (cdb_tag),
      .cdb_wr_en         (cdb_wr_en)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // The winner is the requester closest to the pointer going upward with wrap.
   function automatic int model_grant();
      int best;
      int best_dist;
      best      = -1;
      best_dist = N;
      for (int i = 0; i < N; i++) begin
         if (m_req[i] && ((i - m_ptr + N) % N) < best_dist) begin
            best_dist = (i - m_ptr + N) % N;
            best      = i;
         end
      end
      return best;
   endfunction

   function automatic logic [N-1:0] exp_bcast();
      logic [N-1:0] r;
      int g;
      r = '0;
      g = model_grant();
      if (reset_n && !clear && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   function automatic void model_reset();
      m_req   = '0;
      m_ptr   = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_tag   = '0;
      m_wr    = 1'b0;
   endfunction

   function automatic void model_edge();
      int g;
      g = model_grant();
      if (!reset_n) begin
         model_reset();
      end else begin
         if (g >= 0 && !clear) begin
            m_valid = 1'b1;
            m_data  = fu_result[g];
            m_tag   = fu_dest_tag[g];
            m_wr    = fu_dest_tag_wr_en[g];
            m_ptr   = (g + 1) % N;
         end else begin
            m_valid = 1'b0;
         end
         m_req = fu_next_valid & ~{N{clear}};
      end
   endfunction

   task automatic drive(input logic [N-1:0] nv, input logic c);
      fu_next_valid = nv;
      clear         = c;
      for (int i = 0; i < N; i++) begin
         fu_result[i]         = $urandom;
         fu_dest_tag[i]       = TW'($urandom_range(63, 0));
         fu_dest_tag_wr_en[i] = 1'($urandom_range(1, 0));
      end
   endtask

   task automatic advance();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic flush();
      drive('0, 1'b0);
      repeat (2) advance();
   endtask

   task automatic test_reset();
      #2;
      vectors++;
      if ({fu_broadcasted, cdb_valid, cdb_data, cdb_tag, cdb_wr_en} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got bcast=%b valid=%b data=%h tag=%h wr=%b want all zero",
                  fu_broadcasted, cdb_valid, cdb_data, cdb_tag, cdb_wr_en);
      end
      @(negedge clock);
      #2;
      reset_n = 1'b1;
      drive('1, 1'b0);
      #1;
      vectors++;
      if (fu_broadcasted !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL first_cycle_no_grant: got %b want 0000", fu_broadcasted);
      end
      advance();
      @(negedge clock);
      vectors++;
      if (fu_broadcasted !== 4'b0001) begin
         miscompares++;
         $display("[TB] FAIL post_reset_lowest: got %b want 0001", fu_broadcasted);
      end
      advance();
   endtask

   task automatic test_single();
      flush();
      drive(4'b0001, 1'b0);
      advance();
      drive('0, 1'b0);
      fu_result[0]         = 32'h0000_0005;
      fu_dest_tag[0]       = TW'(3);
      fu_dest_tag_wr_en[0] = 1'b1;
      @(negedge clock);
      vectors++;
      if (fu_broadcasted !== 4'b0001) begin
         miscompares++;
         $display("[TB] FAIL single_grant: got %b want 0001", fu_broadcasted);
      end
      advance();
      drive('0, 1'b0);
      @(negedge clock);
      vectors++;
      if ({cdb_valid, cdb_data, cdb_tag, cdb_wr_en} !== {1'b1, 32'h5, 6'd3, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL single_bcast: got valid=%b data=%h tag=%0d wr=%b want 1/5/3/1",
                  cdb_valid, cdb_data, cdb_tag, cdb_wr_en);
      end
      advance();
      @(negedge clock);
      vectors++;
      if ({cdb_valid, cdb_data, cdb_tag, cdb_wr_en} !== {1'b0, 32'h5, 6'd3, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL single_hold: got valid=%b data=%h tag=%0d wr=%b want 0/5/3/1",
                  cdb_valid, cdb_data, cdb_tag, cdb_wr_en);
      end
      advance();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] want;
      flush();
      drive(4'b1000, 1'b0);
      advance();
      drive('1, 1'b0);
      advance();
      for (int k = 0; k < 5; k++) begin
         drive('1, 1'b0);
         want = 4'b0001 << (k % 4);
         @(negedge clock);
         vectors++;
         if (fu_broadcasted !== want) begin
            miscompares++;
            $display("[TB] FAIL rr_grant[%0d]: got %b want %b", k, fu_broadcasted, want);
         end
         vectors++;
         if ({cdb_valid, cdb_data, cdb_tag, cdb_wr_en} !== {1'b1, m_data, m_tag, m_wr}) begin
            miscompares++;
            $display("[TB] FAIL rr_bcast[%0d]: got %b/%h/%h/%b want 1/%h/%h/%b",
                     k, cdb_valid, cdb_data, cdb_tag, cdb_wr_en, m_data, m_tag, m_wr);
         end
         advance();
      end
   endtask

   task automatic test_wrap();
      flush();
      drive(4'b0100, 1'b0);
      advance();
      drive(4'b1010, 1'b0);
      advance();
      drive(4'b1010, 1'b0);
      @(negedge clock);
      vectors++;
      if (fu_broadcasted !== 4'b1000) begin
         miscompares++;
         $display("[TB] FAIL wrap_fu3: got %b want 1000", fu_broadcasted);
      end
      advance();
      drive('0, 1'b0);
      @(negedge clock);
      vectors++;
      if (fu_broadcasted !== 4'b0010) begin
         miscompares++;
         $display("[TB] FAIL wrap_fu1: got %b want 0010", fu_broadcasted);
      end
      advance();
   endtask

   task automatic test_clear();
      flush();
      drive(4'b0100, 1'b0);
      advance();
      drive(4'b0100, 1'b1);
      @(negedge clock);
      vectors++;
      if (fu_broadcasted !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL clear_grant: got %b want 0000", fu_broadcasted);
      end
      advance();
      drive('0, 1'b0);
      @(negedge clock);
      vectors++;
      if ({fu_broadcasted, cdb_valid} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL clear_after: got bcast=%b valid=%b want 0000/0", fu_broadcasted, cdb_valid);
      end
      vectors++;
      if ({cdb_data, cdb_tag, cdb_wr_en} !== {m_data, m_tag, m_wr}) begin
         miscompares++;
         $display("[TB] FAIL clear_hold: got %h/%h/%b want %h/%h/%b",
                  cdb_data, cdb_tag, cdb_wr_en, m_data, m_tag, m_wr);
      end
      advance();
   endtask

   task automatic test_back_to_back();
      logic [38:0] q[$];
      logic [38:0] want;
      int          seen;
      seen = 0;
      flush();
      for (int k = 0; k < 8; k++) begin
         drive((k < 5) ? 4'b0010 : 4'b0000, 1'b0);
         fu_dest_tag_wr_en[1] = 1'(k % 2);
         @(negedge clock);
         vectors++;
         if (cdb_valid !== m_valid) begin
            miscompares++;
            $display("[TB] FAIL b2b_valid[%0d]: got %b want %b", k, cdb_valid, m_valid);
         end
         if (cdb_valid === 1'b1) seen++;
         if (m_valid) begin
            want = (q.size() > 0) ? q.pop_front() : 39'h0;
            vectors++;
            if ({cdb_data, cdb_tag, cdb_wr_en} !== want) begin
               miscompares++;
               $display("[TB] FAIL b2b_order[%0d]: got %h want %h", k, {cdb_data, cdb_tag, cdb_wr_en}, want);
            end
         end
         if (exp_bcast() == 4'b0010) q.push_back({fu_result[1], fu_dest_tag[1], fu_dest_tag_wr_en[1]});
         advance();
      end
      vectors++;
      if (seen != 5) begin
         miscompares++;
         $display("[TB] FAIL b2b_count: got %0d broadcasts want 5", seen);
      end
   endtask

   task automatic test_reset_mid();
      flush();
      drive(4'b0001, 1'b0);
      advance();
      drive('0, 1'b0);
      advance();
      @(negedge clock);
      vectors++;
      if (cdb_valid !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL midreset_pre: got valid=%b want 1", cdb_valid);
      end
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if ({fu_broadcasted, cdb_valid, cdb_data, cdb_tag, cdb_wr_en} !== '0) begin
         miscompares++;
         $display("[TB] FAIL midreset_async: got bcast=%b valid=%b data=%h tag=%h wr=%b want all zero",
                  fu_broadcasted, cdb_valid, cdb_data, cdb_tag, cdb_wr_en);
      end
      advance();
      reset_n = 1'b1;
      drive(4'b1100, 1'b0);
      @(negedge clock);
      vectors++;
      if (fu_broadcasted !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL midreset_first: got %b want 0000", fu_broadcasted);
      end
      advance();
      drive('0, 1'b0);
      @(negedge clock);
      vectors++;
      if (fu_broadcasted !== 4'b0100) begin
         miscompares++;
         $display("[TB] FAIL midreset_lowest: got %b want 0100", fu_broadcasted);
      end
      advance();
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         drive(N'($urandom), ($urandom_range(15, 0) == 0));
         @(negedge clock);
         vectors++;
         if (fu_broadcasted !== exp_bcast()) begin
            miscompares++;
            $display("[TB] FAIL rand_grant[%0d]: got %b want %b", k, fu_broadcasted, exp_bcast());
         end
         vectors++;
         if ({cdb_valid, cdb_data, cdb_tag, cdb_wr_en} !== {m_valid, m_data, m_tag, m_wr}) begin
            miscompares++;
            $display("[TB] FAIL rand_bcast[%0d]: got %b/%h/%h/%b want %b/%h/%h/%b", k,
                     cdb_valid, cdb_data, cdb_tag, cdb_wr_en, m_valid, m_data, m_tag, m_wr);
         end
         advance();
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      model_reset();
      drive('0, 1'b0);
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_clear();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
